// File: rtl/axil_wr_rd_checker.sv
// axil_wr_rd_checker
//   AXI4-Lite master used for hardware bring-up of a small register-file
//   slave. On an accepted start it walks C_NUM_REGS word addresses from the
//   base address. For each one it writes seed+idx, reads the word back and
//   compares the two. At the end of the run it reports pass/fail, a
//   saturating error count and the index of the first failing register.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for start; status outputs hold the last run's result
//   WRITE  | AW and W channels presented together, each drops after its own handshake
//   WRESP  | BREADY high, waiting for the write response
//   RADDR  | ARVALID high, waiting for ARREADY
//   RDATA  | RREADY high, waiting for the read beat; compare against expected
//   NEXT   | advance idx or finish
//   FINISH | one-cycle done pulse; pass is valid here
//
// Ports
//   M_AXI_ACLK, M_AXI_ARESET   clock, synchronous active-high reset
//   start, seed                run request pulse and pattern seed
//   busy, done, pass, timeout  run status
//   err_count, first_fail_idx  error statistics of the last run
//   M_AXI_*                    AXI4-Lite master interface
module axil_wr_rd_checker #(
    parameter int                            C_M_AXI_ADDR_WIDTH         = 32,
    parameter int                            C_M_AXI_DATA_WIDTH         = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_TARGET_SLAVE_BASE_ADDR = '0,
    parameter int                            C_NUM_REGS                 = 4,
    parameter int                            C_TIMEOUT                  = 1024
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESET,
    input  logic                              start,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     seed,
    output logic                              busy,
    output logic                              done,
    output logic                              pass,
    output logic                              timeout,
    output logic [7:0]                        err_count,
    output logic [7:0]                        first_fail_idx,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WRESP,
        S_RADDR,
        S_RDATA,
        S_NEXT,
        S_FINISH
    } state_t;

    localparam int       TW       = (C_TIMEOUT > 2) ? $clog2(C_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMR_LOAD = TW'(C_TIMEOUT - 1);
    localparam logic [7:0]    LAST_IDX = 8'(C_NUM_REGS - 1);

    state_t                          state, state_nxt;
    logic [7:0]                      idx;
    logic [C_M_AXI_DATA_WIDTH-1:0]   seed_q;
    logic                            aw_done, w_done;
    logic [TW-1:0]                   tmr;
    logic [7:0]                      err_q, ffi_q;
    logic                            pass_q, timeout_q;

    logic [C_M_AXI_DATA_WIDTH-1:0]   data_i;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_i;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs;
    logic active, tmo_hit, beat_err;

    assign data_i = seed_q + C_M_AXI_DATA_WIDTH'(idx);
    assign addr_i = C_M_TARGET_SLAVE_BASE_ADDR +
                    {{(C_M_AXI_ADDR_WIDTH-10){1'b0}}, idx, 2'b00};

    assign aw_hs  = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs   = M_AXI_WVALID  && M_AXI_WREADY;
    assign b_hs   = M_AXI_BVALID  && M_AXI_BREADY;
    assign ar_hs  = M_AXI_ARVALID && M_AXI_ARREADY;
    assign r_hs   = M_AXI_RVALID  && M_AXI_RREADY;
    assign any_hs = aw_hs || w_hs || b_hs || ar_hs || r_hs;

    assign active = (state == S_WRITE) || (state == S_WRESP) ||
                    (state == S_RADDR) || (state == S_RDATA);
    // The wait timer is a down-counter reloaded on every state entry and
    // handshake; reaching zero with no handshake this cycle means C_TIMEOUT
    // cycles have been spent waiting on the same handshake.
    assign tmo_hit = active && (tmr == '0) && !any_hs;

    assign beat_err = (b_hs && (M_AXI_BRESP != 2'b00)) ||
                      (r_hs && ((M_AXI_RRESP != 2'b00) || (M_AXI_RDATA != data_i)));

    // State register and datapath
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state     <= S_IDLE;
            idx       <= '0;
            seed_q    <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            tmr       <= TMR_LOAD;
            err_q     <= '0;
            ffi_q     <= 8'hFF;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_nxt;

            if ((state_nxt != state) || any_hs)
                tmr <= TMR_LOAD;
            else if (tmr != '0)
                tmr <= tmr - TW'(1);

            if (state != S_WRITE) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end

            if ((state == S_IDLE) && start) begin
                seed_q    <= seed;
                idx       <= '0;
                err_q     <= '0;
                ffi_q     <= 8'hFF;
                pass_q    <= 1'b0;
                timeout_q <= 1'b0;
            end

            if (beat_err) begin
                if (err_q != 8'hFF) err_q <= err_q + 8'd1;
                if (ffi_q == 8'hFF) ffi_q <= idx;
            end

            if (tmo_hit) begin
                timeout_q <= 1'b1;
                pass_q    <= 1'b0;
                if (ffi_q == 8'hFF) ffi_q <= idx;
            end

            // pass is settled on the way into FINISH so it is valid with done
            if (state == S_NEXT) begin
                if (idx == LAST_IDX)
                    pass_q <= (err_q == 8'd0) && !timeout_q;
                else
                    idx <= idx + 8'd1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_WRITE;
            S_WRITE: begin
                if (tmo_hit)
                    state_nxt = S_FINISH;
                else if ((aw_done || aw_hs) && (w_done || w_hs))
                    state_nxt = S_WRESP;
            end
            S_WRESP: begin
                if (tmo_hit)   state_nxt = S_FINISH;
                else if (b_hs) state_nxt = S_RADDR;
            end
            S_RADDR: begin
                if (tmo_hit)    state_nxt = S_FINISH;
                else if (ar_hs) state_nxt = S_RDATA;
            end
            S_RDATA: begin
                if (tmo_hit)   state_nxt = S_FINISH;
                else if (r_hs) state_nxt = S_NEXT;
            end
            S_NEXT:   state_nxt = (idx == LAST_IDX) ? S_FINISH : S_WRITE;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        case (state)
            S_WRITE: begin
                M_AXI_AWVALID = !aw_done;
                M_AXI_WVALID  = !w_done;
            end
            S_WRESP: M_AXI_BREADY  = 1'b1;
            S_RADDR: M_AXI_ARVALID = 1'b1;
            S_RDATA: M_AXI_RREADY  = 1'b1;
            default: ;
        endcase
        busy = (state != S_IDLE) && (state != S_FINISH);
        done = (state == S_FINISH);
    end

    assign M_AXI_AWADDR   = addr_i;
    assign M_AXI_ARADDR   = addr_i;
    assign M_AXI_WDATA    = data_i;
    assign M_AXI_AWPROT   = 3'b000;
    assign M_AXI_ARPROT   = 3'b000;
    assign M_AXI_WSTRB    = '1;
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign err_count      = err_q;
    assign first_fail_idx = ffi_q;

endmodule
